fm_tune_ctrl: RTL and testbench
===============================

Name: fm_tune_ctrl

Overview:
- Channel tuning controller that sequences the FM modulator's configuration inputs.
- Holds a channel index and drives the modulator's carrier increment (acc_inc), deviation increment (df_inc) and audio input.
- On a retune it mutes audio, computes the new carrier increment with a sequential shift-add, ramps acc_inc to it glitch-free, then settles and unmutes.
- Sits between the board-level controls and fm_modulator.

Parameters:
- A, 8, audio sample width (signed).
- N, 18, phase increment width; must equal the modulator's N.
- L, 12, deviation increment width.
- CH_W, 7, channel index width.
- NUM_CH, 100, number of valid channels (0..NUM_CH-1); NUM_CH <= 2**CH_W.
- BASE_INC, 52429, acc_inc for channel 0.
- STEP_INC, 524, acc_inc added per channel.
- DF_INC, 393, df_inc value while unmuted.
- RAMP_STEP, 64, maximum acc_inc change per cycle during RAMP.
- MUTE_CYCLES, 16, length of the MUTE and SETTLE phases in cycles (>= 1).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- ch_up  in  1  single-cycle request: next channel.
- ch_down  in  1  single-cycle request: previous channel.
- ch_load  in  1  single-cycle request: jump to ch_value.
- ch_value  in  CH_W  target channel for ch_load.
- audio_in  in  A  signed audio sample.
- audio_out  out  A  signed audio to the modulator; registered.
- acc_inc  out  N  carrier phase increment to the modulator; registered.
- df_inc  out  L  deviation increment to the modulator; registered.
- channel  out  CH_W  committed channel index.
- busy  out  1  high while the retune sequence runs.
- req_drop  out  1  one-cycle pulse when a request is ignored.

Behaviour:
- Reset values (rst high at an edge): channel=0, acc_inc=BASE_INC, df_inc=DF_INC, audio_out=0, busy=0, req_drop=0, FSM=IDLE. Reset mid-sequence aborts immediately to these values.
- Audio path: in IDLE, audio_out <= audio_in (1-cycle latency). In every other state audio_out <= 0.
- States are IDLE, MUTE, CALC, RAMP, SETTLE.
- Request decode in IDLE, priority ch_load > ch_up/ch_down:
  - ch_load with ch_value < NUM_CH and ch_value != channel: target = ch_value.
  - ch_load with ch_value >= NUM_CH: ignored, req_drop pulse.
  - ch_load with ch_value == channel: silently ignored (no pulse).
  - ch_up alone: target = channel+1, wrapping NUM_CH-1 -> 0.
  - ch_down alone: target = channel-1, wrapping 0 -> NUM_CH-1.
  - ch_up and ch_down together with no ch_load: no action, no pulse.
  - Any valid request moves to MUTE on the same edge.
- IDLE -> MUTE: busy=1 and df_inc=0 from the next cycle. Stay in MUTE for exactly MUTE_CYCLES cycles.
- CALC: compute BASE_INC + target*STEP_INC by shift-add, one target bit per cycle, LSB first, exactly CH_W cycles. Arithmetic is modulo 2**N. The result is latched as tgt_inc.
- RAMP: each cycle compute d = |tgt_inc - acc_inc|, using unsigned comparison with no wrap.
  - If d <= RAMP_STEP: acc_inc <= tgt_inc and go to SETTLE.
  - Otherwise move acc_inc by RAMP_STEP toward tgt_inc.
  - Minimum 1 cycle; duration = ceil(d0/RAMP_STEP) cycles, where d0 is d on entry.
- SETTLE: exactly MUTE_CYCLES cycles. On the last edge: channel <= target, df_inc <= DF_INC, busy <= 0, return to IDLE.
- Timing: unmuted audio reappears on audio_out one cycle after IDLE is re-entered.
- Requests arriving in any non-IDLE state are ignored and pulse req_drop for one cycle. They are never queued.
- acc_inc changes only in RAMP or on reset. df_inc changes only on the IDLE->MUTE edge, the SETTLE->IDLE edge, or reset.
- The channel output updates only at the end of SETTLE.

Test Plan:
- Reset: assert rst for 2 cycles with audio_in=0x40 -> acc_inc=52429, df_inc=393, channel=0, busy=0, audio_out=0; one cycle after release, audio_out=0x40.
- Single up: pulse ch_up -> busy next cycle, audio_out=0, df_inc=0. Phases last MUTE 16, CALC 7, RAMP 9, SETTLE 16 cycles. Then acc_inc=52953, channel=1, df_inc=393, busy=0. Monotonic acc_inc steps, each <= 64.
- Wrap-down: from channel 0, pulse ch_down -> channel=99, acc_inc=52429+99*524=104305 (mod 2^18). Ramp lasts ceil(51876/64)=811 cycles.
- Load decode: ch_load with ch_value=120 -> req_drop pulse, no busy. ch_load with ch_value=0 while channel=0 -> no action, no pulse. ch_up and ch_down together -> no action.
- Busy collision: during RAMP pulse ch_up, then ch_load -> req_drop for each, final channel unchanged from the original target.
- Reset mid-RAMP: assert rst -> next cycle acc_inc=52429, channel=0, df_inc=393, busy=0. A subsequent ch_up completes normally.

Source files
------------

// File: rtl/fm_tune_ctrl.sv
// fm_tune_ctrl
// -----------------------------------------------------------------------------
// Channel tuning controller in front of fm_modulator. It holds the committed
// channel index and drives the modulator's carrier increment (acc_inc),
// deviation increment (df_inc) and audio input (audio_out).
//
// A retune goes through these states:
//   IDLE -> MUTE (MUTE_CYCLES) -> CALC (CH_W) -> RAMP (>=1) -> SETTLE
//   (MUTE_CYCLES) -> IDLE
// During the sequence, audio is forced to zero and df_inc is held at zero.
// CALC forms BASE_INC + target*STEP_INC with a serial shift-add, one target
// bit per cycle, starting at the LSB. RAMP slews acc_inc toward the result
// by at most RAMP_STEP per cycle, so the carrier never jumps.
//
// Request handshake: ch_up, ch_down and ch_load are single-cycle strobes and
// are sampled on every rising edge. In IDLE a valid request is accepted on
// that edge, and busy rises after it. Any strobe seen outside IDLE, and a
// ch_load to an out-of-range channel, is dropped. A dropped request gives a
// one-cycle req_drop pulse on the following cycle. Nothing is queued.
//
// Ports:
//   clk, rst       clock; synchronous active-high reset
//   ch_up/ch_down  step the channel up/down with wrap-around
//   ch_load        jump to ch_value
//   ch_value       target channel for ch_load
//   audio_in       audio sample; registered to audio_out while IDLE
//   audio_out      audio to the modulator (zero while busy)
//   acc_inc        carrier phase increment (registered)
//   df_inc         deviation increment (registered, zero while busy)
//   channel        committed channel index
//   busy           retune sequence in progress
//   req_drop       one-cycle pulse for an ignored request
// -----------------------------------------------------------------------------
module fm_tune_ctrl #(
  parameter int A           = 8,
  parameter int N           = 18,
  parameter int L           = 12,
  parameter int CH_W        = 7,
  parameter int NUM_CH      = 100,
  parameter int BASE_INC    = 52429,
  parameter int STEP_INC    = 524,
  parameter int DF_INC      = 393,
  parameter int RAMP_STEP   = 64,
  parameter int MUTE_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ch_up,
  input  logic            ch_down,
  input  logic            ch_load,
  input  logic [CH_W-1:0] ch_value,
  input  logic [A-1:0]    audio_in,
  output logic [A-1:0]    audio_out,
  output logic [N-1:0]    acc_inc,
  output logic [L-1:0]    df_inc,
  output logic [CH_W-1:0] channel,
  output logic            busy,
  output logic            req_drop
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MUTE   = 3'd1,
    S_CALC   = 3'd2,
    S_RAMP   = 3'd3,
    S_SETTLE = 3'd4
  } state_t;

  // A single counter serves the MUTE, CALC and SETTLE phases. It must be
  // wide enough for the longest of them.
  localparam int CNT_MAX = (MUTE_CYCLES > CH_W) ? MUTE_CYCLES : CH_W;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] MUTE_LAST = CNT_W'(MUTE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CALC_LAST = CNT_W'(CH_W - 1);
  localparam logic [N-1:0]     BASE_N    = N'(BASE_INC);
  localparam logic [N-1:0]     STEP_N    = N'(STEP_INC);
  localparam logic [N-1:0]     RAMP_N    = N'(RAMP_STEP);
  localparam logic [L-1:0]     DF_L      = L'(DF_INC);
  localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(NUM_CH - 1);
  // The limit gets one extra bit so that NUM_CH == 2**CH_W is representable.
  localparam logic [CH_W:0]    NUM_CH_X  = (CH_W + 1)'(NUM_CH);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CH_W-1:0]   channel_q, channel_d;
  logic [CH_W-1:0]   target_q, target_d;
  logic [N-1:0]      acc_inc_q, acc_inc_d;
  logic [N-1:0]      tgt_inc_q, tgt_inc_d;   // shift-add accumulator, then ramp goal
  logic [N-1:0]      step_sh_q, step_sh_d;   // STEP_INC << bit index
  logic [CH_W-1:0]   tgt_sh_q, tgt_sh_d;     // target bits still to consume
  logic [L-1:0]      df_inc_q, df_inc_d;
  logic [A-1:0]      audio_q, audio_d;
  logic              busy_q, busy_d;
  logic              req_drop_q, req_drop_d;

  logic              req_valid;
  logic [CH_W-1:0]   req_tgt;
  logic              ramp_up;
  logic [N-1:0]      ramp_dist;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    channel_d  = channel_q;
    target_d   = target_q;
    acc_inc_d  = acc_inc_q;
    tgt_inc_d  = tgt_inc_q;
    step_sh_d  = step_sh_q;
    tgt_sh_d   = tgt_sh_q;
    df_inc_d   = df_inc_q;
    req_valid  = 1'b0;
    req_tgt    = channel_q;
    audio_d    = (state_q == S_IDLE) ? audio_in : '0;
    // Outside IDLE, any strobe is ignored and reported.
    req_drop_d = (state_q != S_IDLE) && (ch_up || ch_down || ch_load);

    // Unsigned distance to the goal. There is no modular wrap here, so the
    // ramp always takes the direct path between the two increments.
    ramp_up   = (tgt_inc_q >= acc_inc_q);
    ramp_dist = ramp_up ? (tgt_inc_q - acc_inc_q) : (acc_inc_q - tgt_inc_q);

    case (state_q)
      S_IDLE: begin
        if (ch_load) begin
          if ({1'b0, ch_value} >= NUM_CH_X) begin
            req_drop_d = 1'b1;
          end else if (ch_value != channel_q) begin
            req_valid = 1'b1;
            req_tgt   = ch_value;
          end
        end else if (ch_up && !ch_down) begin
          req_valid = 1'b1;
          req_tgt   = (channel_q == CH_LAST) ? '0 : channel_q + CH_W'(1);
        end else if (ch_down && !ch_up) begin
          req_valid = 1'b1;
          req_tgt   = (channel_q == '0) ? CH_LAST : channel_q - CH_W'(1);
        end
        if (req_valid) begin
          target_d = req_tgt;
          state_d  = S_MUTE;
          cnt_d    = '0;
          df_inc_d = '0;
        end
      end

      S_MUTE: begin
        if (cnt_q == MUTE_LAST) begin
          state_d   = S_CALC;
          cnt_d     = '0;
          tgt_inc_d = BASE_N;
          step_sh_d = STEP_N;
          tgt_sh_d  = target_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_CALC: begin
        if (tgt_sh_q[0]) begin
          tgt_inc_d = tgt_inc_q + step_sh_q;
        end
        step_sh_d = step_sh_q << 1;
        tgt_sh_d  = tgt_sh_q >> 1;
        if (cnt_q == CALC_LAST) begin
          state_d = S_RAMP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_RAMP: begin
        if (ramp_dist <= RAMP_N) begin
          acc_inc_d = tgt_inc_q;
          state_d   = S_SETTLE;
          cnt_d     = '0;
        end else if (ramp_up) begin
          acc_inc_d = acc_inc_q + RAMP_N;
        end else begin
          acc_inc_d = acc_inc_q - RAMP_N;
        end
      end

      S_SETTLE: begin
        if (cnt_q == MUTE_LAST) begin
          state_d   = S_IDLE;
          channel_d = target_q;
          df_inc_d  = DF_L;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      channel_q  <= '0;
      target_q   <= '0;
      acc_inc_q  <= BASE_N;
      tgt_inc_q  <= BASE_N;
      step_sh_q  <= '0;
      tgt_sh_q   <= '0;
      df_inc_q   <= DF_L;
      audio_q    <= '0;
      busy_q     <= 1'b0;
      req_drop_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      channel_q  <= channel_d;
      target_q   <= target_d;
      acc_inc_q  <= acc_inc_d;
      tgt_inc_q  <= tgt_inc_d;
      step_sh_q  <= step_sh_d;
      tgt_sh_q   <= tgt_sh_d;
      df_inc_q   <= df_inc_d;
      audio_q    <= audio_d;
      busy_q     <= busy_d;
      req_drop_q <= req_drop_d;
    end
  end

  assign audio_out = audio_q;
  assign acc_inc   = acc_inc_q;
  assign df_inc    = df_inc_q;
  assign channel   = channel_q;
  assign busy      = busy_q;
  assign req_drop  = req_drop_q;

endmodule

// File: tb/tb_fm_tune_ctrl.sv
// tb_fm_tune_ctrl
// Directed bench for fm_tune_ctrl. Each accepted retune pushes its expected
// {channel, acc_inc} onto exp_q. The entry is popped and compared when busy
// falls. Phase timing, ramp shape, muting and req_drop are checked inline.
module tb_fm_tune_ctrl;
  localparam int A      = 8;
  localparam int N      = 18;
  localparam int L      = 12;
  localparam int CH_W   = 7;
  localparam int NUM_CH = 100;
  localparam int BASE   = 52429;
  localparam int STEP   = 524;
  localparam int DF     = 393;
  localparam int RSTEP  = 64;
  localparam int MUTE   = 16;
  localparam int BOUND  = 5000;

  logic            clk = 1'b0;
  logic            rst;
  logic            ch_up, ch_down, ch_load;
  logic [CH_W-1:0] ch_value;
  logic [A-1:0]    audio_in, audio_out;
  logic [N-1:0]    acc_inc;
  logic [L-1:0]    df_inc;
  logic [CH_W-1:0] channel;
  logic            busy, req_drop;

  int n_checks = 0;
  int n_fail   = 0;
  int model_ch = 0;
  logic [CH_W+N-1:0] exp_q[$];

  always #5 clk = ~clk;

  fm_tune_ctrl dut (
    .clk(clk), .rst(rst), .ch_up(ch_up), .ch_down(ch_down), .ch_load(ch_load),
    .ch_value(ch_value), .audio_in(audio_in), .audio_out(audio_out),
    .acc_inc(acc_inc), .df_inc(df_inc), .channel(channel), .busy(busy),
    .req_drop(req_drop)
  );

  // Clock/reset helpers and checker.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model.
  function automatic int inc_of(input int ch);
    return (BASE + ch * STEP) % (1 << N);
  endfunction

  function automatic int ramp_len(input int from, input int to);
    int d;
    d = (to > from) ? to - from : from - to;
    return (d <= RSTEP) ? 1 : (d + RSTEP - 1) / RSTEP;
  endfunction

  // Driver: kind 0=up, 1=down, 2=load(val). If coll_k >= 0, a ch_up strobe is
  // driven at busy-cycle coll_k and a ch_load at coll_k+2. Both must be dropped.
  task automatic retune(input int kind, input int val, input int coll_k);
    int tgt, start_inc, tgt_inc, ramp, k, first, nchg;
    logic [N-1:0] prev;
    logic [A-1:0] last_audio;
    logic [CH_W+N-1:0] e;
    case (kind)
      0:       tgt = (model_ch + 1) % NUM_CH;
      1:       tgt = (model_ch + NUM_CH - 1) % NUM_CH;
      default: tgt = val;
    endcase
    start_inc = inc_of(model_ch);
    tgt_inc   = inc_of(tgt);
    ramp      = ramp_len(start_inc, tgt_inc);
    exp_q.push_back({CH_W'(tgt), N'(tgt_inc)});

    ch_up = (kind == 0); ch_down = (kind == 1); ch_load = (kind == 2);
    ch_value = CH_W'(val);
    step();
    ch_up = 1'b0; ch_down = 1'b0; ch_load = 1'b0;
    chk("busy_rise", busy, 1);
    chk("df_mute", df_inc, 0);

    k = 0; first = -1; nchg = 0; prev = acc_inc; last_audio = audio_in;
    while (busy === 1'b1 && k < BOUND) begin
      ch_up    = (coll_k >= 0) && (k == coll_k);
      ch_load  = (coll_k >= 0) && (k == coll_k + 2);
      ch_value = CH_W'(50);
      audio_in = A'($urandom_range(1, 255));
      last_audio = audio_in;
      step();
      ch_up = 1'b0; ch_load = 1'b0;
      k++;
      if (k == 2) chk("audio_muted", audio_out, 0);
      if (coll_k >= 0 && (k == coll_k + 1 || k == coll_k + 3))
        chk("drop_busy", req_drop, 1);
      if (acc_inc !== prev) begin
        if (first < 0) first = k;
        nchg++;
        chk("ramp_step", (tgt_inc > start_inc) ?
            (acc_inc > prev && (acc_inc - prev) <= RSTEP) :
            (acc_inc < prev && (prev - acc_inc) <= RSTEP), 1);
        prev = acc_inc;
      end
    end
    chk("busy_timeout", k < BOUND, 1);
    chk("busy_len", k, 2 * MUTE + CH_W + ramp);
    chk("ramp_start", first, MUTE + CH_W + 1);
    chk("ramp_cycles", nchg, ramp);
    e = exp_q.pop_front();
    chk("channel", channel, e[CH_W+N-1:N]);
    chk("acc_inc", acc_inc, e[N-1:0]);
    chk("df_restore", df_inc, DF);
    chk("audio_last0", audio_out, 0);
    step();
    chk("audio_unmute", audio_out, last_audio);
    model_ch = tgt;
  endtask

  // Drive one idle-time request that must not start a sequence.
  task automatic idle_req(input string tag, input logic up, input logic dn,
                          input logic ld, input int val, input logic exp_drop);
    ch_up = up; ch_down = dn; ch_load = ld; ch_value = CH_W'(val);
    step();
    ch_up = 1'b0; ch_down = 1'b0; ch_load = 1'b0;
    chk({tag, "_drop"}, req_drop, exp_drop);
    chk({tag, "_busy"}, busy, 0);
    step();
    chk({tag, "_drop_end"}, req_drop, 0);
    chk({tag, "_busy2"}, busy, 0);
    chk({tag, "_channel"}, channel, model_ch);
  endtask

  initial begin
    rst = 1'b1; ch_up = 1'b0; ch_down = 1'b0; ch_load = 1'b0;
    ch_value = '0; audio_in = 8'h40;

    // Reset values.
    step(); step();
    chk("rst_acc", acc_inc, BASE);
    chk("rst_df", df_inc, DF);
    chk("rst_channel", channel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_audio", audio_out, 0);
    chk("rst_drop", req_drop, 0);
    rst = 1'b0;
    step();
    chk("audio_pass", audio_out, 8'h40);

    // Single up: 0 -> 1.
    retune(0, 0, -1);
    // Down with dropped strobes during RAMP: 1 -> 0.
    retune(1, 0, 25);

    // Idle decode at channel 0.
    idle_req("load_oob", 1'b0, 1'b0, 1'b1, 120, 1'b1);
    idle_req("load_same", 1'b0, 1'b0, 1'b1, 0, 1'b0);
    idle_req("up_and_down", 1'b1, 1'b1, 1'b0, 0, 1'b0);

    // Wrap down: 0 -> 99, long ramp.
    retune(1, 0, -1);
    // Load: 99 -> 10, long downward ramp.
    retune(2, 10, -1);

    // Reset mid-RAMP during 10 -> 11.
    ch_up = 1'b1;
    step();
    ch_up = 1'b0;
    for (int i = 0; i < 27; i++) step();
    chk("midramp_moving", acc_inc != N'(inc_of(10)), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_acc", acc_inc, BASE);
    chk("mrst_channel", channel, 0);
    chk("mrst_df", df_inc, DF);
    chk("mrst_busy", busy, 0);
    model_ch = 0;
    step();

    // Sequence after the abort must still finish normally.
    retune(0, 0, -1);

    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
